victim_wb_ctrl: RTL and testbench
=================================

VICTIM_WB_CTRL -- requirements
Module: victim_wb_ctrl

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 256: victim line data width in bits.
REQ-002 SHALL have parameter BUS_WIDTH, default 32: memory write-data width in bits; BEATS = LINE_WIDTH/BUS_WIDTH, default 8.
REQ-003 SHALL derive LABEL_WIDTH = 32 - log2(LINE_WIDTH/8), default 27.
REQ-004 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port vc_empty, input, 1: victim cache holds no lines.
REQ-007 SHALL have port vc_rline, input, LABEL_WIDTH+LINE_WIDTH: victim cache head line as {label, data}, valid when vc_empty=0.
REQ-008 SHALL have port vc_pop, output, 1: one-cycle pop strobe to the victim cache.
REQ-009 SHALL have port mem_awaddr, output, 32: burst write address.
REQ-010 SHALL have ports mem_awvalid (output, 1) and mem_awready (input, 1): address handshake.
REQ-011 SHALL have ports mem_wdata (output, BUS_WIDTH), mem_wvalid (output, 1), mem_wlast (output, 1) and mem_wready (input, 1): data beats.
REQ-012 SHALL have ports mem_bvalid (input, 1) and mem_bready (output, 1): write response.
REQ-013 SHALL have port flush_req, input, 1: level request to drain the victim cache.
REQ-014 SHALL have port flush_done, output, 1: drain complete.
REQ-015 SHALL have port busy, output, 1: a writeback is in progress (state != IDLE).

Function
REQ-016 SHALL implement FSM states IDLE, ADDR, DATA, RESP.
REQ-017 IDLE with vc_empty=0 SHALL latch vc_rline into an internal line buffer, assert vc_pop for exactly that cycle, and go to ADDR.
REQ-018 IDLE with vc_empty=1 SHALL keep vc_pop=0 and stay in IDLE.
REQ-019 ADDR SHALL hold mem_awvalid=1 with mem_awaddr = {buffered label, log2(LINE_WIDTH/8) zero bits}, and go to DATA on the cycle mem_awready=1.
REQ-020 DATA SHALL hold mem_wvalid=1 and drive beat k = buffer data bits [k*BUS_WIDTH +: BUS_WIDTH], starting at k=0.
REQ-021 DATA SHALL advance the beat counter only when mem_wready=1, and hold wdata stable otherwise.
REQ-022 mem_wlast SHALL be 1 only while k = BEATS-1; mem_wready=1 at that beat SHALL go to RESP.
REQ-023 RESP SHALL hold mem_bready=1 and go to IDLE on the cycle mem_bvalid=1; the next line is popped no earlier than the following cycle.
REQ-024 awvalid, wvalid and bready SHALL never be asserted in the same cycle; each is valid only in its own state.
REQ-025 Once asserted, valid signals SHALL NOT drop before their handshake completes.
REQ-026 Minimum writeback latency, with ready and bvalid tied high, SHALL be 1 (IDLE) + 1 (ADDR) + BEATS (DATA) + 1 (RESP) = 11 cycles per line at default parameters.
REQ-027 flush_done SHALL be 1 combinationally when flush_req=1, state=IDLE and vc_empty=1; otherwise 0.
REQ-028 Writebacks SHALL proceed regardless of flush_req; flush_req only qualifies flush_done.
REQ-029 Lines pushed into the victim cache during a writeback SHALL NOT affect the buffered line.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, beat counter 0 and line buffer 0, and drive vc_pop, mem_awvalid, mem_wvalid, mem_wlast, mem_bready, busy and flush_done to 0, with mem_awaddr = 0 and mem_wdata = 0.
REQ-031 rst asserted mid-burst SHALL abandon the burst without re-popping; the popped line is lost.
REQ-032 The first pop after rst deasserts SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-033 Single line: vc_rline = {27'h0000123, 256'h…7_6_5_4_3_2_1_0 words 0..7}, vc_empty=1 after the pop, all readies high -> one vc_pop pulse; awaddr = 32'h00002460; wdata beats 0..7; wlast on beat 7; back to IDLE after 11 cycles.
REQ-034 Backpressure: mem_awready low for 3 cycles, mem_wready low on beats 2 and 5 -> awaddr and wdata held stable; no beat skipped or duplicated; 13 beat-cycles total.
REQ-035 Back-to-back: 3 lines queued (labels 1, 2, 3) -> exactly 3 pops, each spaced at least 11 cycles apart; addresses 0x20, 0x40, 0x60 issued in order.
REQ-036 Flush: flush_req=1 with 2 lines queued -> flush_done=0 until the second bvalid; flush_done=1 on the next cycle, when IDLE and empty.
REQ-037 Mid-burst reset: rst pulsed during beat 4 -> all outputs 0 immediately; after release with vc_empty=1, no awvalid is issued.
REQ-038 Slow response: mem_bvalid delayed 5 cycles -> bready held high throughout and no vc_pop until 1 cycle after bvalid.

Source files
------------

// File: rtl/victim_wb_ctrl_if.sv
// Memory write-burst bus between the victim writeback controller and memory.
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both 1; once valid is raised, it and its payload
// stay stable until that edge.
interface victim_wb_ctrl_if #(
  parameter int BUS_WIDTH = 32
);
  logic [31:0]          awaddr;
  logic                 awvalid;
  logic                 awready;
  logic [BUS_WIDTH-1:0] wdata;
  logic                 wvalid;
  logic                 wlast;
  logic                 wready;
  logic                 bvalid;
  logic                 bready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, wlast, bready,
    input  awready, wready, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, wlast, bready,
    output awready, wready, bvalid
  );
endinterface

// File: rtl/victim_wb_ctrl.sv
// Victim cache writeback controller: pops one line at a time from the victim
// cache into a local buffer, then writes it to memory as one address phase,
// BEATS data beats and one write response. flush_done reports an idle, empty
// victim cache while a flush is requested.
module victim_wb_ctrl #(
  parameter  int LINE_WIDTH  = 256,
  parameter  int BUS_WIDTH   = 32,
  localparam int OFFS_W      = $clog2(LINE_WIDTH / 8),
  localparam int LABEL_WIDTH = 32 - OFFS_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              vc_empty,
  input  logic [LABEL_WIDTH+LINE_WIDTH-1:0] vc_rline,
  output logic                              vc_pop,
  victim_wb_ctrl_if.master                  mem,
  input  logic                              flush_req,
  output logic                              flush_done,
  output logic                              busy,
  output logic [1:0]                        dbg_state_o
);

  localparam int BEATS  = LINE_WIDTH / BUS_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [LABEL_WIDTH-1:0] label_q;
  logic [LINE_WIDTH-1:0]  data_q;
  logic                   pop_c;
  logic                   awvalid_c;
  logic                   wvalid_c;
  logic                   wlast_c;
  logic                   bready_c;

  // State, beat counter and line buffer; the buffer only loads on a pop so
  // later pushes into the victim cache cannot disturb a line in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      label_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (vc_pop) begin
        label_q <= vc_rline[LABEL_WIDTH+LINE_WIDTH-1:LINE_WIDTH];
        data_q  <= vc_rline[LINE_WIDTH-1:0];
      end
    end
  end

  // Next state and per-state handshake outputs; each valid/ready belongs to
  // exactly one state, so the three channels can never overlap.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    pop_c     = 1'b0;
    awvalid_c = 1'b0;
    wvalid_c  = 1'b0;
    wlast_c   = 1'b0;
    bready_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!vc_empty) begin
          pop_c   = 1'b1;
          beat_d  = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        awvalid_c = 1'b1;
        if (mem.awready) state_d = S_DATA;
      end
      S_DATA: begin
        wvalid_c = 1'b1;
        wlast_c  = (beat_q == LAST_BEAT);
        if (mem.wready) begin
          if (wlast_c) begin
            beat_d  = '0;
            state_d = S_RESP;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_RESP: begin
        bready_c = 1'b1;
        if (mem.bvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The pop and flush_done terms depend on inputs, so they are masked while
  // reset is held; everything else is a pure function of the reset state.
  assign vc_pop      = pop_c && !rst;
  assign flush_done  = flush_req && (state_q == S_IDLE) && vc_empty && !rst;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

  assign mem.awaddr  = {label_q, {OFFS_W{1'b0}}};
  assign mem.awvalid = awvalid_c;
  assign mem.wdata   = data_q[int'(beat_q)*BUS_WIDTH +: BUS_WIDTH];
  assign mem.wvalid  = wvalid_c;
  assign mem.wlast   = wlast_c;
  assign mem.bready  = bready_c;

endmodule

// File: tb/tb_victim_wb_ctrl.sv
// Bench for victim_wb_ctrl: a victim-cache queue model and a memory responder
// with programmable stalls drive the DUT; a monitor pops expected addresses
// and beats from queues filled when each line is pushed.
module tb_victim_wb_ctrl;

  localparam int LW   = 256;
  localparam int BW   = 32;
  localparam int LABW = 27;

  typedef logic [LABW+LW-1:0] line_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        vc_empty;
  line_t       vc_rline;
  logic        vc_pop;
  logic        flush_req;
  logic        flush_done;
  logic        busy;
  logic [1:0]  dbg_state;

  victim_wb_ctrl_if #(.BUS_WIDTH(BW)) mem ();

  victim_wb_ctrl #(.LINE_WIDTH(LW), .BUS_WIDTH(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .vc_empty   (vc_empty),
    .vc_rline   (vc_rline),
    .vc_pop     (vc_pop),
    .mem        (mem),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  line_t       vc_q[$];
  logic [31:0] exp_aw_q[$];
  logic [32:0] exp_w_q[$];
  int          lat_q[$];
  int          pop_cyc_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          aw_seen = 0;

  // responder configuration and bookkeeping
  int          aw_stall = 0;
  logic [7:0]  w_mask = 8'h00;
  int          b_delay = 0;
  int          aw_cnt = 0;
  int          b_cnt = 0;
  int          w_idx = 0;
  int          b_hs = 0;
  logic        w_stalled = 1'b0;
  logic        pop_now;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void update_vc();
    vc_empty = (vc_q.size() == 0);
    vc_rline = vc_empty ? '0 : vc_q[0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_line(input logic [LABW-1:0] label, input logic [LW-1:0] data,
                           input logic [31:0] addr);
    vc_q.push_back({label, data});
    update_vc();
    exp_aw_q.push_back(addr);
    for (int k = 0; k < 8; k++)
      exp_w_q.push_back({(k == 7) ? 1'b1 : 1'b0, data[k*BW +: BW]});
  endtask

  task automatic wait_lines(input int n, input int budget);
    int k;
    k = 0;
    while (lat_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check("lines_done", 64'(lat_q.size()), 64'(n));
  endtask

  task automatic set_resp(input int aws, input logic [7:0] wm, input int bd);
    aw_stall = aws; w_mask = wm; b_delay = bd;
    aw_cnt = 0; b_cnt = 0; w_idx = 0; b_hs = 0; w_stalled = 1'b0;
    lat_q.delete();
    pop_cyc_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pop"},    64'(vc_pop), 64'd0);
    check({tag, "_awv"},    64'(mem.awvalid), 64'd0);
    check({tag, "_wv"},     64'(mem.wvalid), 64'd0);
    check({tag, "_wlast"},  64'(mem.wlast), 64'd0);
    check({tag, "_bready"}, 64'(mem.bready), 64'd0);
    check({tag, "_busy"},   64'(busy), 64'd0);
    check({tag, "_fdone"},  64'(flush_done), 64'd0);
    check({tag, "_awaddr"}, 64'(mem.awaddr), 64'd0);
    check({tag, "_wdata"},  64'(mem.wdata), 64'd0);
    check({tag, "_state"},  64'(dbg_state), 64'd0);
  endtask

  task automatic check_pops(input string tag, input int n, input int spacing);
    check({tag, "_pops"}, 64'(pop_cyc_q.size()), 64'(n));
    for (int i = 1; i < pop_cyc_q.size(); i++)
      check({tag, "_spacing"}, 64'(pop_cyc_q[i] - pop_cyc_q[i-1]), 64'(spacing));
    for (int i = 0; i < lat_q.size(); i++)
      check({tag, "_latency"}, 64'(lat_q[i]), 64'(spacing));
    check({tag, "_aw_left"}, 64'(exp_aw_q.size()), 64'd0);
    check({tag, "_w_left"},  64'(exp_w_q.size()), 64'd0);
  endtask

  // ---------------- victim cache + memory responder ----------------
  // Decides the readies for the coming edge at the falling edge, then retires
  // a popped line just after the rising edge that took it.
  initial begin
    mem.awready = 1'b0;
    mem.wready  = 1'b0;
    mem.bvalid  = 1'b0;
    forever begin
      @(negedge clk);
      pop_now = vc_pop;
      if (mem.awvalid) begin
        if (aw_cnt < aw_stall) begin mem.awready = 1'b0; aw_cnt++; end
        else begin mem.awready = 1'b1; aw_cnt = 0; end
      end else mem.awready = 1'b0;
      if (mem.wvalid) begin
        if (w_mask[w_idx[2:0]] && !w_stalled) begin mem.wready = 1'b0; w_stalled = 1'b1; end
        else begin mem.wready = 1'b1; w_stalled = 1'b0; w_idx = (w_idx + 1) % 8; end
      end else mem.wready = 1'b0;
      if (mem.bready) begin
        if (b_cnt < b_delay) begin mem.bvalid = 1'b0; b_cnt++; end
        else begin mem.bvalid = 1'b1; b_cnt = 0; b_hs++; end
      end else mem.bvalid = 1'b0;
      @(posedge clk);
      #1;
      if (pop_now && !rst && vc_q.size() > 0) begin
        void'(vc_q.pop_front());
        update_vc();
      end
    end
  end

  // ---------------- monitor ----------------
  logic        aw_hold = 1'b0, w_hold = 1'b0, b_hold = 1'b0, in_wb = 1'b0;
  logic [31:0] aw_prev;
  logic [32:0] w_prev;
  int          lat = 0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        aw_hold = 1'b0; w_hold = 1'b0; b_hold = 1'b0; in_wb = 1'b0;
      end else begin
        check("one_channel", 64'(int'(mem.awvalid) + int'(mem.wvalid) + int'(mem.bready) <= 1), 64'd1);
        if (aw_hold) check("aw_stable", {31'd0, mem.awvalid, mem.awaddr}, {31'd0, 1'b1, aw_prev});
        if (w_hold)  check("w_stable",  {30'd0, mem.wvalid, mem.wlast, mem.wdata}, {30'd0, 1'b1, w_prev});
        if (b_hold)  check("b_hold",    64'(mem.bready), 64'd1);
        if (mem.awvalid && mem.awready) begin
          aw_seen++;
          if (exp_aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
          else check("awaddr", 64'(mem.awaddr), 64'(exp_aw_q.pop_front()));
        end
        if (mem.wvalid && mem.wready) begin
          if (exp_w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
          else check("wbeat", 64'({mem.wlast, mem.wdata}), 64'(exp_w_q.pop_front()));
        end
        aw_hold = mem.awvalid && !mem.awready;
        aw_prev = mem.awaddr;
        w_hold  = mem.wvalid && !mem.wready;
        w_prev  = {mem.wlast, mem.wdata};
        b_hold  = mem.bready && !mem.bvalid;
        if (in_wb) begin
          if (busy) lat++;
          else begin lat_q.push_back(lat); in_wb = 1'b0; end
        end
        if (vc_pop) begin
          pop_cyc_q.push_back(cyc);
          in_wb = 1'b1;
          lat = 1;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [LW-1:0] d;

  initial begin
    rst = 1'b1;
    flush_req = 1'b1;
    update_vc();
    #3;
    check_all_zero("reset");
    repeat (3) step();
    @(negedge clk);
    #3;
    rst = 1'b0;
    step();
    check("flush_idle_empty", 64'(flush_done), 64'd1);
    flush_req = 1'b0;
    #1;
    check("flush_released", 64'(flush_done), 64'd0);

    // single line, words 0..7, label 0x123
    set_resp(0, 8'h00, 0);
    for (int k = 0; k < 8; k++) d[k*BW +: BW] = 32'(k);
    push_line(27'h0000123, d, 32'h00002460);
    wait_lines(1, 100);
    check_pops("single", 1, 11);

    // address stalled 3 cycles, beats 2 and 5 stalled once each
    set_resp(3, 8'b0010_0100, 0);
    for (int k = 0; k < 8; k++) d[k*BW +: BW] = 32'hC0DE_0000 + 32'(k * 17);
    push_line(27'h00ABCDE, d, 32'h01579BC0);
    wait_lines(1, 100);
    check_pops("backpressure", 1, 16);

    // three lines queued back to back
    set_resp(0, 8'h00, 0);
    for (int n = 1; n <= 3; n++) begin
      for (int k = 0; k < 8; k++) d[k*BW +: BW] = {8'(n), 8'hA5, 16'(k)};
      push_line(27'(n), d, 32'(n * 32));
    end
    wait_lines(3, 200);
    check_pops("b2b", 3, 11);

    // response delayed 5 cycles on two lines
    set_resp(0, 8'h00, 5);
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 8; k++) d[k*BW +: BW] = 32'h5A5A_0000 ^ 32'(k + n * 8);
      push_line(27'h4000000 + 27'(n), d, (n == 0) ? 32'h80000000 : 32'h80000020);
    end
    wait_lines(2, 200);
    check_pops("slow_resp", 2, 16);

    // flush with two lines queued
    set_resp(0, 8'h00, 0);
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 8; k++) d[k*BW +: BW] = 32'hF00D_0000 + 32'(k + n);
      push_line(27'h10 + 27'(n), d, (n == 0) ? 32'h00000200 : 32'h00000220);
    end
    flush_req = 1'b1;
    begin
      int k;
      k = 0;
      while (b_hs < 2 && k < 100) begin
        check("flush_early", 64'(flush_done), 64'd0);
        step();
        k++;
      end
    end
    check("flush_done", 64'(flush_done), 64'd1);
    flush_req = 1'b0;
    #1;
    check("flush_drop", 64'(flush_done), 64'd0);
    wait_lines(2, 20);
    check_pops("flush", 2, 11);

    // reset during beat 4 of a burst
    set_resp(0, 8'h00, 0);
    for (int k = 0; k < 8; k++) d[k*BW +: BW] = 32'hDEAD_0000 + 32'(k);
    push_line(27'h7, d, 32'h000000E0);
    begin
      int k;
      k = 0;
      while (w_idx < 4 && k < 50) begin
        step();
        k++;
      end
      check("reach_beat4", 64'(w_idx >= 4), 64'd1);
    end
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    repeat (2) step();
    exp_aw_q.delete();
    exp_w_q.delete();
    set_resp(0, 8'h00, 0);
    aw_seen = 0;
    @(negedge clk);
    #3;
    rst = 1'b0;
    repeat (20) step();
    check("no_aw_after_reset", 64'(aw_seen), 64'd0);
    check("idle_after_reset", 64'(busy), 64'd0);
    check("no_pop_after_reset", 64'(pop_cyc_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
